// File: rtl/lfsr_pkg.sv
// lfsr_pkg: structure selectors, maximal tap masks and the default seed shared by the LFSR generator
package lfsr_pkg;
  localparam int MODE_FIB = 0;
  localparam int MODE_GAL = 1;
  localparam logic [3:0] TAPS_4 = 4'hC;
  localparam logic [7:0] TAPS_8 = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'h80200003;
  localparam int DEF_SEED = 1;
endpackage

// File: rtl/lfsr_next.sv
// lfsr_next: combinational LFSR step, state_i -> next_o (Fibonacci shifts left with XOR feedback into bit 0, Galois shifts right XORing TAPS when bit 0 is set)
module lfsr_next import lfsr_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAPS_8),
  parameter int MODE = MODE_FIB
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);
  always_comb next_o = (MODE == MODE_GAL) ? ((state_i >> 1) ^ (state_i[0] ? TAPS : '0))
                                          : {state_i[WIDTH-2:0], ^(state_i & TAPS)};
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: LFSR word source with seed load, zero-seed lockup guard, valid/ready output and period measurement; ports clk, rst, en, load, seed_in, rnd_ready in; rnd_valid, rnd_out, wrap, lockup, period_out, period_vld out
module lfsr_gen import lfsr_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAPS_8),
  parameter int MODE = MODE_FIB,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_out,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] period_out,
  output logic             period_vld
);
  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be within 3..32");
  end
  if (!TAPS[WIDTH-1]) begin : g_bad_taps
    $error("lfsr_gen: TAPS must have bit WIDTH-1 set");
  end
  logic [WIDTH-1:0] state_q, state_d, start_q, start_d, step_q, step_d, period_q, period_d, nxt, seed_eff;
  logic valid_q, valid_d, wrap_q, wrap_d, lockup_q, lockup_d, pvld_q, pvld_d;
  logic accept, hit, zero_seed;
  lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS), .MODE(MODE)) u_next (
    .state_i(state_q),
    .next_o (nxt)
  );
  assign accept = en & valid_q & rnd_ready;
  assign hit = accept & (nxt == start_q);
  assign zero_seed = seed_in == '0;
  assign seed_eff = zero_seed ? SEED : seed_in;
  // load pre-empts any accept in the same cycle, so every term tests load first
  always_comb begin
    state_d = load ? seed_eff : accept ? nxt : state_q;
    start_d = load ? seed_eff : start_q;
    step_d = (load | hit) ? '0 : accept ? step_q + 1'b1 : step_q;
    period_d = (!load && hit) ? step_q + 1'b1 : period_q;
    pvld_d = load ? 1'b0 : hit ? 1'b1 : pvld_q;
    valid_d = !load && en;
    wrap_d = !load && hit;
    lockup_d = load && zero_seed;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
      start_q <= SEED;
      step_q <= '0;
      period_q <= '0;
      pvld_q <= 1'b0;
      valid_q <= 1'b0;
      wrap_q <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      step_q <= step_d;
      period_q <= period_d;
      pvld_q <= pvld_d;
      valid_q <= valid_d;
      wrap_q <= wrap_d;
      lockup_q <= lockup_d;
    end
  end
  assign rnd_out = state_q;
  assign rnd_valid = valid_q;
  assign wrap = wrap_q;
  assign lockup = lockup_q;
  assign period_out = period_q;
  assign period_vld = pvld_q;
endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised pseudo-random generator for the lab's stimulus and test-pattern sources.
- Successor to the fixed 8-bit LFSR. Adds:
  - configurable width, taps and structure (Fibonacci or Galois);
  - runtime seed load with zero-seed lock-up protection;
  - a valid/ready output handshake;
  - hardware period measurement with wrap detection.
- Sits between the free-running clock domain logic and any consumer of random words (display, checker, scrambler).

Parameters:
- WIDTH, 8: LFSR state width in bits. Legal range 3..32.
- TAPS, 8'hB8: tap mask, WIDTH bits. Bit i set means state bit i is in the feedback polynomial. 8'hB8 = x^8+x^6+x^5+x^4+1, which is maximal.
- MODE, 0: 0 = Fibonacci (shift left, XOR feedback into bit 0); 1 = Galois (shift right, conditional XOR of TAPS).
- SEED, 1: default non-zero state. Used at reset and as the substitute for a zero seed.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  generator enable; when 0, the state is frozen and rnd_valid is 0.
- load  in  1  one-cycle request to load seed_in.
- seed_in  in  WIDTH  seed value sampled when load=1.
- rnd_ready  in  1  consumer accepts rnd_out this cycle.
- rnd_valid  out  1  rnd_out holds an unconsumed value.
- rnd_out  out  WIDTH  current LFSR state.
- wrap  out  1  one-cycle pulse when the sequence returns to its start value.
- lockup  out  1  one-cycle pulse when a zero seed was rejected.
- period_out  out  WIDTH  length of the last completed cycle, in accepted steps.
- period_vld  out  1  period_out holds a valid measurement.

Behaviour:
- Reset (rst=1 at a clk edge), all registered:
  - state=SEED, start=SEED, step_cnt=0;
  - rnd_valid=0, wrap=0, lockup=0;
  - period_out=0, period_vld=0.
- Priority per cycle: rst > load > advance.
- Advance condition: accept = en & rnd_valid & rnd_ready.
  - On accept: state <= next(state); step_cnt <= step_cnt+1.
  - Latency: the new value appears on rnd_out the cycle after accept.
- Next-state function:
  - Fibonacci: next = {state[WIDTH-2:0], ^(state & TAPS)}.
  - Galois: next = (state >> 1) ^ (state[0] ? TAPS : 0).
- Load (load=1, rst=0):
  - If seed_in != 0: state <= seed_in and start <= seed_in.
  - If seed_in == 0: state <= SEED, start <= SEED, lockup <= 1 for one cycle.
  - In both cases:
    - step_cnt <= 0;
    - period_vld <= 0;
    - rnd_valid <= 0 for exactly one cycle, then it follows en.
  - A simultaneous accept is ignored; the consumer's handshake is not honoured that cycle.
- rnd_valid:
  - Registered; equals en delayed one cycle.
  - Forced 0 in the cycle after reset and in the cycle after a load.
  - While en=0: state, step_cnt and the period registers hold.
- Handshake:
  - rnd_out is stable while rnd_valid=1 and rnd_ready=0.
  - Each accepted value is consumed exactly once; no skipping, no duplication.
- Wrap:
  - Raised when accept occurs and next(state) == start.
  - That cycle: wrap <= 1 (one cycle); period_out <= step_cnt+1; period_vld <= 1; step_cnt <= 0.
  - Sequence continues uninterrupted.
  - step_cnt is WIDTH bits. It cannot overflow because the maximal period is 2^WIDTH-1.
  - A non-maximal TAPS simply reports the shorter period.
- The all-zero state is unreachable: reset and load never produce it, and next(nonzero) is nonzero for any TAPS with bit WIDTH-1 set.
  - TAPS must have bit WIDTH-1 set; check this with an elaboration-time assertion.
- Reset mid-run: discards the current state and period measurement and restarts from SEED on the next edge.

Decomposition:
- Package lfsr_pkg:
  - MODE_FIB=0 and MODE_GAL=1 constants;
  - maximal tap constants TAPS_4=4'hC, TAPS_8=8'hB8, TAPS_16=16'hB400, TAPS_32=32'h80200003;
  - default SEED=1.
- Sub-module lfsr_next: purely combinational, parameterised by WIDTH, TAPS and MODE. Maps state to next. Reused by the checker model.
- lfsr_gen holds all registers: state, start, step_cnt, period registers, handshake and pulses.

Test Plan:
- Fibonacci, WIDTH=8, TAPS=B8, reset, en=1, rnd_ready=1 -> rnd_out sequence 0x01, 0x02, 0x04, 0x08, 0x11; rnd_valid=0 in the first cycle after reset.
- Galois, same parameters -> rnd_out sequence 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3.
- Free run for 300 accepts -> wrap pulses exactly at accept #255; period_out=255; period_vld=1; all 255 values distinct and non-zero. Repeat with WIDTH=4, TAPS=4'hC -> period 15.
- load=1, seed_in=0 -> lockup pulses once; rnd_out=0x01; rnd_valid=0 for one cycle; period_vld=0. Then load seed_in=0x5A -> rnd_out=0x5A; next wrap occurs when the state returns to 0x5A, after 255 accepts.
- Backpressure: rnd_ready toggled randomly and en dropped for 3 cycles -> rnd_out holds while not accepted; the accepted stream equals the reference model sequence with no gaps or repeats.
- Corner cases:
  - rst asserted mid-run with load=1 and accept in the same cycle -> reset wins, state=SEED;
  - load together with accept -> load wins and the accept is dropped.
